// File: rtl/eq_band_sequencer.sv
// Cascade sequencer for NBANDS biquad bands; gain writes are serialised between samples. Optional EQ_BYPASS_EN adds per-band skip.
// Latency: 2 + (stepped bands)*(SETTLE+1) cycles from sample acceptance to o_out_valid.
// Backpressure: o_sample_ready low outside S_IDLE and while a gain write is arriving or being served.
module eq_band_sequencer #(
  parameter int NBANDS   = 4,
  parameter int SETTLE   = 33,
  parameter int SET_WAIT = 33
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sample_valid,
  input  logic [31:0]          i_sample,
  output logic                 o_sample_ready,
  input  logic                 i_gain_we,
  input  logic [2:0]           i_gain_band,
  input  logic [15:0]          i_gain,
  output logic                 o_gain_busy,
  output logic [NBANDS-1:0]    o_bq_set,
  output logic [15:0]          o_bq_gain,
  output logic [NBANDS-1:0]    o_bq_next,
  output logic [31:0]          o_bq_data,
  input  logic [NBANDS*32-1:0] i_bq_data,
`ifdef EQ_BYPASS_EN
  input  logic [NBANDS-1:0]    i_bypass,
`endif
  output logic [31:0]          o_out,
  output logic                 o_out_valid
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_SET, S_SETWAIT, S_STEP, S_SETTLE, S_OUT
  } state_t;

  typedef struct packed {
    logic [2:0]  band;
    logic [15:0] gain;
  } gain_req_t;

  state_t            state, state_d;
  logic [15:0]       cnt;
  logic [2:0]        band;
  logic [31:0]       work;
  logic              pending;
  gain_req_t         gain_q;
  logic [NBANDS-1:0] byp_q;
  logic [NBANDS-1:0] byp_in;
  logic [NBANDS-1:0] search_mask;
  logic [3:0]        search_from;
  logic              nxt_found;
  logic [2:0]        nxt_idx;
  logic              gain_ok, gain_accept, sample_accept;
  logic              wait_done, settle_done;
  logic [31:0]       band_out;

`ifdef EQ_BYPASS_EN
  assign byp_in = i_bypass;
`else
  assign byp_in = '0;
`endif

  assign gain_ok        = {29'd0, i_gain_band} < 32'(NBANDS);
  assign o_gain_busy    = (state != S_IDLE) || pending;
  assign gain_accept    = i_gain_we && !o_gain_busy && gain_ok;
  assign o_sample_ready = (state == S_IDLE) && !pending && !gain_accept;
  assign sample_accept  = i_sample_valid && o_sample_ready;
  assign wait_done      = (cnt == 16'(SET_WAIT - 1));
  assign settle_done    = (cnt == 16'(SETTLE - 1));
  assign o_bq_gain      = gain_q.gain;
  assign o_bq_data      = work;

  // Lowest non-bypassed band at or above search_from; the mask comes from
  // the live input at acceptance and from the latched copy afterwards.
  always_comb begin
    search_mask = byp_q;
    search_from = {1'b0, band} + 4'd1;
    if (state == S_IDLE) begin
      search_mask = byp_in;
      search_from = '0;
    end
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int k = NBANDS - 1; k >= 0; k--) begin
      if ((k >= int'(search_from)) && !search_mask[k]) begin
        nxt_found = 1'b1;
        nxt_idx   = 3'(k);
      end
    end
  end

  always_comb begin
    band_out = '0;
    for (int k = 0; k < NBANDS; k++) begin
      if (band == 3'(k)) band_out = i_bq_data[k*32 +: 32];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_INIT;
    else       state <= state_d;
  end

  always_comb begin
    state_d   = state;
    o_bq_set  = '0;
    o_bq_next = '0;
    case (state)
      S_INIT:    if (wait_done) state_d = S_IDLE;
      S_IDLE: begin
        if (pending || gain_accept) state_d = S_SET;
        else if (sample_accept)     state_d = nxt_found ? S_STEP : S_OUT;
      end
      S_SET:     state_d = S_SETWAIT;
      S_SETWAIT: if (wait_done) state_d = S_IDLE;
      S_STEP:    state_d = S_SETTLE;
      S_SETTLE:  if (settle_done) state_d = nxt_found ? S_STEP : S_OUT;
      S_OUT:     state_d = S_IDLE;
      default:   state_d = S_INIT;
    endcase
    for (int k = 0; k < NBANDS; k++) begin
      o_bq_set[k]  = (state == S_SET)  && (gain_q.band == 3'(k));
      o_bq_next[k] = (state == S_STEP) && (band == 3'(k));
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt         <= '0;
      band        <= '0;
      work        <= '0;
      pending     <= 1'b0;
      gain_q      <= '0;
      byp_q       <= '0;
      o_out       <= '0;
      o_out_valid <= 1'b0;
    end else begin
      cnt         <= (state_d != state) ? 16'd0 : cnt + 16'd1;
      o_out_valid <= (state == S_OUT);
      if (state == S_OUT) o_out <= work;

      if (gain_accept) begin
        pending     <= 1'b1;
        gain_q.band <= i_gain_band;
        gain_q.gain <= i_gain;
      end else if ((state == S_SETWAIT) && wait_done) begin
        pending <= 1'b0;
      end

      if (sample_accept) begin
        work  <= i_sample;
        byp_q <= byp_in;
        band  <= nxt_idx;
      end else if ((state == S_SETTLE) && settle_done) begin
        work <= band_out;
        if (nxt_found) band <= nxt_idx;
      end
    end
  end

endmodule

// File: tb/tb_eq_band_sequencer.sv
// Bench for eq_band_sequencer: band models add a per-band offset after a 33-cycle settle; expectations come
// from a cascade model (sample + sum of stepped offsets, 2 + steps*34 latency, 34-cycle pulse spacing).
module tb_eq_band_sequencer;
  localparam int NB  = 4;
  localparam int ST  = 33;
  localparam int SW  = 33;
  localparam int PER = ST + 1;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_sample_valid;
  logic [31:0]      i_sample;
  logic             o_sample_ready;
  logic             i_gain_we;
  logic [2:0]       i_gain_band;
  logic [15:0]      i_gain;
  logic             o_gain_busy;
  logic [NB-1:0]    o_bq_set;
  logic [15:0]      o_bq_gain;
  logic [NB-1:0]    o_bq_next;
  logic [31:0]      o_bq_data;
  logic [NB*32-1:0] i_bq_data;
  logic [31:0]      o_out;
  logic             o_out_valid;
  logic [NB-1:0]    byp_cfg = '0;
`ifdef EQ_BYPASS_EN
  logic [NB-1:0]    i_bypass;
  assign i_bypass = byp_cfg;
`endif

  eq_band_sequencer #(.NBANDS(NB), .SETTLE(ST), .SET_WAIT(SW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_sample_valid(i_sample_valid), .i_sample(i_sample), .o_sample_ready(o_sample_ready),
    .i_gain_we(i_gain_we), .i_gain_band(i_gain_band), .i_gain(i_gain), .o_gain_busy(o_gain_busy),
    .o_bq_set(o_bq_set), .o_bq_gain(o_bq_gain), .o_bq_next(o_bq_next), .o_bq_data(o_bq_data),
    .i_bq_data(i_bq_data),
`ifdef EQ_BYPASS_EN
    .i_bypass(i_bypass),
`endif
    .o_out(o_out), .o_out_valid(o_out_valid)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Band models: output becomes sent+add only from settle cycle 33; garbage before that.
  logic [31:0] add     [NB];
  logic [31:0] sent    [NB];
  logic [31:0] bq_out  [NB];
  int          age     [NB];
  int          unstable = 0;

  initial for (int k = 0; k < NB; k++) begin
    add[k] = '0; sent[k] = '0; bq_out[k] = '0; age[k] = 0;
  end

  always_comb begin
    for (int k = 0; k < NB; k++) i_bq_data[k*32 +: 32] = bq_out[k];
  end

  always @(posedge i_clk) begin
    for (int k = 0; k < NB; k++) begin
      if (i_rst) begin
        age[k] <= 0;
      end else if (o_bq_next[k]) begin
        sent[k]   <= o_bq_data;
        age[k]    <= 1;
        bq_out[k] <= 32'hBAD0_0000 | 32'(k);
      end else if (age[k] > 0 && age[k] < 40) begin
        if (age[k] <= ST && o_bq_data !== sent[k]) unstable++;
        if (age[k] == ST - 1) bq_out[k] <= sent[k] + add[k];
        age[k] <= age[k] + 1;
      end
    end
  end

  int            next_cyc[$];
  logic [NB-1:0] next_vec[$];
  int            set_cyc[$];
  logic [NB-1:0] set_vec[$];
  logic [15:0]   set_gain[$];
  int            out_cyc[$];
  logic [31:0]   out_dat[$];
  int            onehot_err = 0;

  always @(negedge i_clk) begin
    if (o_bq_next != '0) begin next_cyc.push_back(cyc); next_vec.push_back(o_bq_next); end
    if (o_bq_set != '0) begin
      set_cyc.push_back(cyc); set_vec.push_back(o_bq_set); set_gain.push_back(o_bq_gain);
    end
    if ($countones({o_bq_set, o_bq_next}) > 1) onehot_err++;
    if (o_out_valid) begin out_cyc.push_back(cyc); out_dat.push_back(o_out); end
  end

  task automatic offer(input logic [31:0] s, output int a);
    a = -1;
    i_sample = s;
    i_sample_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      #1;
      if (o_sample_ready) begin a = cyc; break; end
      @(negedge i_clk);
    end
    if (a >= 0) @(negedge i_clk);
    i_sample_valid = 1'b0;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!o_sample_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
  endtask

  // Sends one sample and measures it against the cascade model.
  task automatic drive_sample(input logic [31:0] s, output int a,
                              output int lat_got, output int lat_exp,
                              output logic [31:0] dat_got, output logic [31:0] dat_exp,
                              output int pulses_bad);
    int steps[$];
    next_cyc.delete(); next_vec.delete(); out_cyc.delete(); out_dat.delete();
    dat_exp = s;
    for (int k = 0; k < NB; k++) if (!byp_cfg[k]) begin dat_exp += add[k]; steps.push_back(k); end
    lat_exp = 2 + steps.size() * PER;
    offer(s, a);
    repeat (lat_exp + 3) @(negedge i_clk);
    lat_got = (a >= 0 && out_cyc.size() == 1) ? out_cyc[0] - a : -1;
    dat_got = (out_dat.size() > 0) ? out_dat[0] : 32'hXXXX_XXXX;
    pulses_bad = 0;
    if (next_cyc.size() != steps.size()) pulses_bad = 1000 + next_cyc.size();
    else for (int j = 0; j < steps.size(); j++)
      if (next_cyc[j] != a + 1 + j * PER || next_vec[j] !== NB'(1) << steps[j]) pulses_bad++;
  endtask

  task automatic test_reset();
    int n;
    i_rst = 1'b1; i_sample_valid = 0; i_sample = '0; i_gain_we = 0; i_gain_band = '0; i_gain = '0;
    repeat (3) @(negedge i_clk);
    #1;
    n_tests++;
    if (o_sample_ready !== 1'b0 || o_gain_busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_handshake: ready=%b busy=%b, required ready=0 busy=1", o_sample_ready, o_gain_busy);
    end
    n_tests++;
    if ({o_bq_set, o_bq_next, o_bq_gain, o_bq_data, o_out, o_out_valid} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: set=%b next=%b gain=%h data=%h out=%h vld=%b, required all 0",
                         o_bq_set, o_bq_next, o_bq_gain, o_bq_data, o_out, o_out_valid);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    i_sample_valid = 1'b1;
    wait_init(n);
    i_sample_valid = 1'b0;
    n_tests++;
    if (n != SW) begin n_fail++; $display("FAIL init_ready_delay: got %0d cycles, required %0d", n, SW); end
    n_tests++;
    if (o_gain_busy !== 1'b0) begin n_fail++; $display("FAIL init_busy_fall: busy=%b, required 0", o_gain_busy); end
    @(negedge i_clk);
  endtask

  task automatic test_identity();
    int a, lg, le, pb; logic [31:0] dg, de;
    for (int k = 0; k < NB; k++) add[k] = '0;
    drive_sample(32'h0000_8000, a, lg, le, dg, de, pb);
    n_tests++;
    if (lg != 138) begin n_fail++; $display("FAIL identity_latency: got %0d, required 138", lg); end
    n_tests++;
    if (dg !== 32'h0000_8000) begin n_fail++; $display("FAIL identity_data: got %h, required 00008000", dg); end
    n_tests++;
    if (pb != 0) begin n_fail++; $display("FAIL identity_next_pulses: %0d bad, required 0", pb); end
  endtask

  task automatic test_offsets();
    int a, lg, le, pb; logic [31:0] dg, de;
    for (int k = 0; k < NB; k++) add[k] = 32'h100 * 32'(k + 1);
    unstable = 0;
    drive_sample(32'h0, a, lg, le, dg, de, pb);
    n_tests++;
    if (dg !== 32'h0000_0A00) begin n_fail++; $display("FAIL offsets_data: got %h, required 00000A00", dg); end
    n_tests++;
    if (unstable != 0) begin n_fail++; $display("FAIL settle_data_stable: %0d changes, required 0", unstable); end
  endtask

  task automatic test_random();
    int a, lg, le, pb; logic [31:0] dg, de;
    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k < NB; k++) add[k] = $urandom;
      repeat ($urandom_range(0, 5)) @(negedge i_clk);
      drive_sample($urandom, a, lg, le, dg, de, pb);
      n_tests++;
      if (lg != le) begin n_fail++; $display("FAIL rand%0d_latency: got %0d, required %0d", t, lg, le); end
      n_tests++;
      if (dg !== de) begin n_fail++; $display("FAIL rand%0d_data: got %h, required %h", t, dg, de); end
      n_tests++;
      if (pb != 0) begin n_fail++; $display("FAIL rand%0d_next_pulses: %0d bad, required 0", t, pb); end
    end
  endtask

  task automatic test_gain_collide();
    int w, a, lg, le, pb; logic [31:0] dg, de; logic [31:0] s;
    int sc; logic [NB-1:0] sv; logic [15:0] sg;
    s = $urandom;
    set_cyc.delete(); set_vec.delete(); set_gain.delete();
    i_gain_we = 1'b1; i_gain_band = 3'd2; i_gain = 16'hFFFA;
    i_sample = s; i_sample_valid = 1'b1;
    #1;
    w = cyc;
    n_tests++;
    if (o_sample_ready !== 1'b0) begin n_fail++; $display("FAIL collide_ready: got %b, required 0", o_sample_ready); end
    @(negedge i_clk);
    i_gain_we = 1'b0;
    repeat (4) @(negedge i_clk);
    i_gain_we = 1'b1; i_gain_band = 3'd1; i_gain = 16'h0007;
    #1;
    n_tests++;
    if (o_gain_busy !== 1'b1 || o_bq_gain !== 16'hFFFA) begin
      n_fail++; $display("FAIL collide_busy_gain: busy=%b gain=%h, required 1 fffa", o_gain_busy, o_bq_gain);
    end
    @(negedge i_clk);
    i_gain_we = 1'b0;
    drive_sample(s, a, lg, le, dg, de, pb);
    sc = (set_cyc.size() > 0) ? set_cyc[0] : -1;
    sv = (set_vec.size() > 0) ? set_vec[0] : '0;
    sg = (set_gain.size() > 0) ? set_gain[0] : '0;
    n_tests++;
    if (set_cyc.size() != 1 || sc != w + 1) begin
      n_fail++; $display("FAIL set_pulse: count=%0d at +%0d, required 1 at +1", set_cyc.size(), sc - w);
    end
    n_tests++;
    if (sv !== 4'b0100 || sg !== 16'hFFFA) begin
      n_fail++; $display("FAIL set_value: set=%b gain=%h, required 0100 fffa", sv, sg);
    end
    n_tests++;
    if (a != sc + PER) begin n_fail++; $display("FAIL accept_after_set: got +%0d, required +%0d", a - sc, PER); end
    n_tests++;
    if (dg !== de || lg != le) begin
      n_fail++; $display("FAIL collide_sample: data=%h lat=%0d, required %h %0d", dg, lg, de, le);
    end
  endtask

  task automatic test_gain_drop();
    int busy_cnt;
    busy_cnt = 0;
    set_cyc.delete(); set_vec.delete(); set_gain.delete();
    i_gain_we = 1'b1; i_gain_band = 3'd5; i_gain = 16'h0123;
    @(negedge i_clk);
    i_gain_we = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (o_gain_busy) busy_cnt++;
      @(negedge i_clk);
    end
    n_tests++;
    if (busy_cnt != 0) begin n_fail++; $display("FAIL drop_busy: busy for %0d cycles, required 0", busy_cnt); end
    n_tests++;
    if (set_cyc.size() != 0) begin n_fail++; $display("FAIL drop_set: %0d set pulses, required 0", set_cyc.size()); end
  endtask

  task automatic test_reset_mid();
    int a, n, lg, le, pb; logic [31:0] dg, de;
    next_cyc.delete(); next_vec.delete();
    offer($urandom, a);
    n = 0;
    while (next_cyc.size() < 2 && n < 200) begin @(negedge i_clk); n++; end
    repeat (5) @(negedge i_clk);
    n_tests++;
    if (next_cyc.size() != 2) begin n_fail++; $display("FAIL midreset_reach_band1: %0d pulses, required 2", next_cyc.size()); end
    out_cyc.delete(); out_dat.delete();
    i_rst = 1'b1;
    #1;
    n_tests++;
    if ({o_bq_set, o_bq_next, o_bq_gain, o_bq_data, o_out, o_out_valid, o_sample_ready} !== '0 || o_gain_busy !== 1'b1) begin
      n_fail++; $display("FAIL midreset_outputs: set=%b next=%b data=%h out=%h busy=%b, required zeros busy=1",
                         o_bq_set, o_bq_next, o_bq_data, o_out, o_gain_busy);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    wait_init(n);
    n_tests++;
    if (n != SW) begin n_fail++; $display("FAIL midreset_init: got %0d cycles, required %0d", n, SW); end
    repeat (150) @(negedge i_clk);
    n_tests++;
    if (out_cyc.size() != 0) begin n_fail++; $display("FAIL midreset_stale_out: %0d strobes, required 0", out_cyc.size()); end
    drive_sample($urandom, a, lg, le, dg, de, pb);
    n_tests++;
    if (dg !== de || lg != le || pb != 0) begin
      n_fail++; $display("FAIL midreset_resume: data=%h lat=%0d bad=%0d, required %h %0d 0", dg, lg, pb, de, le);
    end
  endtask

`ifdef EQ_BYPASS_EN
  task automatic test_bypass();
    int a, lg, le, pb; logic [31:0] dg, de;
    byp_cfg = 4'b1111;
    drive_sample(32'h1234_5678, a, lg, le, dg, de, pb);
    n_tests++;
    if (lg != 2 || dg !== 32'h1234_5678 || pb != 0) begin
      n_fail++; $display("FAIL bypass_all: lat=%0d data=%h bad=%0d, required 2 12345678 0", lg, dg, pb);
    end
    byp_cfg = 4'b0101;
    drive_sample($urandom, a, lg, le, dg, de, pb);
    n_tests++;
    if (lg != le || dg !== de || pb != 0) begin
      n_fail++; $display("FAIL bypass_partial: lat=%0d data=%h bad=%0d, required %0d %h 0", lg, dg, pb, le, de);
    end
    byp_cfg = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_identity();
    test_offsets();
    test_random();
    test_gain_collide();
    test_gain_drop();
`ifdef EQ_BYPASS_EN
    test_bypass();
`endif
    test_reset_mid();
    n_tests++;
    if (onehot_err != 0) begin n_fail++; $display("FAIL onehot_set_next: %0d cycles with >1 bit, required 0", onehot_err); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eq_band_sequencer.md
Name: eq_band_sequencer

Overview:
- Initiator side of the biquad band interface: drives the set (i_set/i_gain) and step (i_next/i_data) inputs of NBANDS biquad peaking bands and collects their o_data.
- Bands are processed as a cascade: one input sample goes through band 0, then band 1, up to band NBANDS-1, with one band stepped at a time.
- Sits between the audio sample source (codec receive side) and the playback/visualiser consumers.
- Serialises user gain writes with sample processing so coefficients never change while a band is stepping.

Parameters:
- NBANDS, 4, number of cascaded biquad bands (1..8).
- SETTLE, 33, cycles from the o_bq_next pulse (cycle 0) to the capture of band output.
- SET_WAIT, 33, cycles a band is blocked after an o_bq_set pulse, and also after reset.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_sample_valid  in  1  input sample offered
- i_sample  in  32  Q15 signed sample
- o_sample_ready  out  1  sample accepted when valid&&ready
- i_gain_we  in  1  gain write strobe
- i_gain_band  in  3  target band index
- i_gain  in  16  signed dB gain
- o_gain_busy  out  1  high while a gain write is pending or in progress
- o_bq_set  out  NBANDS  one-hot set pulse per band
- o_bq_gain  out  16  gain bus shared by all bands
- o_bq_next  out  NBANDS  one-hot step pulse per band
- o_bq_data  out  32  sample bus shared by all bands
- i_bq_data  in  NBANDS*32  band k output at bits [32k+31:32k]
- o_out  out  32  fully filtered sample
- o_out_valid  out  1  one-cycle strobe marking o_out valid

Behaviour:
Reset values:
- o_sample_ready=0, o_gain_busy=1.
- o_bq_set=0, o_bq_next=0, o_bq_gain=0, o_bq_data=0.
- o_out=0, o_out_valid=0.
- State after reset is S_INIT.

States:
- S_INIT: counts SET_WAIT cycles (biquads self-initialise from reset), then goes to S_IDLE.
- S_IDLE:
  - o_gain_busy=0 and o_sample_ready=1 unless a gain write is pending.
  - If a pending gain exists, go to S_SET.
  - Otherwise, on valid&&ready, latch i_sample into the working register, set band=0, go to S_STEP.
- S_SET:
  - o_bq_set[band_g]=1 for exactly one cycle, with o_bq_gain=held gain.
  - Next state is S_SETWAIT.
- S_SETWAIT:
  - Counts SET_WAIT cycles, then clears the pending flag and returns to S_IDLE.
  - o_bq_gain stays stable for the whole wait.
- S_STEP:
  - o_bq_data=working register; o_bq_next[band]=1 for one cycle (cycle 0).
  - Next state is S_SETTLE.
- S_SETTLE:
  - o_bq_data is held stable through cycle SETTLE-1.
  - In cycle SETTLE, capture i_bq_data[band] into the working register.
  - If band<NBANDS-1: band++ and go to S_STEP. Otherwise go to S_OUT.
- S_OUT: o_out=working register, o_out_valid=1 for one cycle, then S_IDLE. o_out holds its value until the next S_OUT.

Gain writes:
- A write is accepted only when i_gain_we=1, o_gain_busy=0 and i_gain_band<NBANDS; accepted writes are latched into a single holding register.
- Writes while busy, or to an out-of-range band, are dropped silently.
- o_gain_busy=1 from the cycle after acceptance until S_SETWAIT completes. It is also 1 in S_INIT and whenever the state is not S_IDLE.

Simultaneous events and boundaries:
- Gain write and sample valid in the same S_IDLE cycle: the gain is latched, ready is driven 0 combinationally from i_gain_we, and the gain is served first.
- Latency per sample = 1 + NBANDS*(SETTLE+1) + 1 cycles from acceptance to o_out_valid (138 cycles for defaults).
- Data path is a pass-through: no arithmetic and no saturation; width is 32 throughout.
- Reset mid-operation aborts immediately: all outputs return to reset values, the pending gain is lost, and the in-flight sample is discarded.
- At most one bit of o_bq_set|o_bq_next is ever set in any cycle.

Optional Feature:
- Macro EQ_BYPASS_EN.
- When defined:
  - Adds input port i_bypass [NBANDS].
  - i_bypass is sampled when the sample is accepted.
  - Bypassed bands are skipped: no o_bq_next pulse, the working register is unchanged, and no cycles are spent.
  - If all bands are bypassed, o_out_valid fires 2 cycles after acceptance with o_out=i_sample.
- When undefined: the port is absent and every band is always stepped.

Test Plan:
- Reset, then hold i_sample_valid=1 → o_sample_ready stays 0 for 33 cycles, then rises; o_gain_busy falls at the same cycle.
- Bench identity models (i_bq_data[k]=o_bq_data latched at next+32); send 0x0000_8000 → o_bq_next bits 0..3 pulse 34 cycles apart; o_out=0x0000_8000 with o_out_valid 138 cycles after acceptance.
- Band models add 0x100*(k+1) at capture; send 0 → o_out=0x0000_0A00; o_bq_data stays constant over each 33-cycle settle window.
- Gain write band=2, gain=-6, in the same cycle as sample valid → o_bq_set=4'b0100 for 1 cycle with o_bq_gain=0xFFFA; sample accepted 34 cycles later; a second write while busy produces no o_bq_set.
- Gain write with band=5 (NBANDS=4) → dropped: no o_bq_set, o_gain_busy stays 0.
- Assert i_rst during S_SETTLE of band 1 → all outputs zero immediately; after release, 33-cycle init, then normal operation with no stale o_out_valid.
